coord_fb_writer: RTL and testbench
==================================

// Module: coord_fb_writer
// PURPOSE
//  Downstream stage of the shape generators (rectangle/line coordinate emitters).
//  Takes the signed (x,y) coordinate stream, clips it to the framebuffer and buffers it.
//  Converts each surviving pixel to a linear address and writes it to a single-port framebuffer RAM.
//  Reports per-frame statistics and raises a done pulse once the generator finishes and all writes have drained.
// PARAMETERS
//  IN_W     32  width of signed input coordinates (matches generator _out0/_out1)
//  FB_W     64  framebuffer width in pixels
//  FB_H     48  framebuffer height in pixels
//  ADDR_W   12  RAM address width; must satisfy 2**ADDR_W >= FB_W*FB_H
//  COLOR_W   8  pixel data width
//  DEPTH     8  FIFO entries (power of two, >=2)
// PORTS
//  _clock        in   1        system clock, all logic on posedge
//  _reset        in   1        synchronous, active-high reset
//  _in_valid     in   1        coordinate present on _in_x/_in_y
//  _in_x         in   IN_W     signed x (generator _out0)
//  _in_y         in   IN_W     signed y (generator _out1)
//  _in_done      in   1        generator finished; level or pulse, sampled when high
//  _in_ready     out  1        coordinate accepted this cycle if _in_valid
//  _color        in   COLOR_W  pixel value, sampled with each accepted coordinate
//  _mem_we       out  1        write request to framebuffer RAM
//  _mem_addr     out  ADDR_W   y*FB_W + x
//  _mem_data     out  COLOR_W  pixel value
//  _mem_ready    in   1        RAM accepts write when _mem_we & _mem_ready
//  _busy         out  1        state != IDLE
//  _frame_done   out  1        one-cycle pulse at end of frame
//  _pix_count    out  16       pixels written this frame, saturating
//  _clip_count   out  16       coordinates clipped this frame, saturating
//  _overflow     out  1        sticky: _in_valid seen while FIFO full
// BEHAVIOUR
//  Reset: all outputs 0 (_in_ready 0 during reset), FIFO empty, state IDLE, counters 0.
//   Reset mid-frame discards FIFO contents; no write is issued in the cycle after reset.
//  Accept: _in_valid & _in_ready. _in_ready = !fifo_full & state in {IDLE,RUN}.
//  Clip: drop the coordinate if x<0, x>=FB_W, y<0 or y>=FB_H (signed compare on full IN_W).
//   Each drop increments _clip_count. Otherwise push {addr, _color}.
//  Address: y*FB_W + x, computed at full width, truncated to ADDR_W after the bounds check.
//  Latency: an accepted in-bounds pixel drives _mem_we at the earliest 1 cycle after accept (registered FIFO head).
//  Output: _mem_we = !fifo_empty. Pop and _pix_count++ on _mem_we & _mem_ready.
//   _mem_addr/_mem_data hold stable while _mem_we & !_mem_ready.
//  Push and pop in the same cycle are legal when not full; occupancy is unchanged.
//  _in_valid while full: coordinate lost, _overflow set, held until reset or next frame start.
//  States:
//   IDLE  -> RUN on first accept; counters and _overflow cleared in that same cycle, then the event is counted.
//   RUN   -> DRAIN when _in_done=1; a coordinate accepted in the same cycle is still processed.
//   DRAIN -> DONE when FIFO empty and no write pending. No new accepts in DRAIN.
//   DONE  -> IDLE after 1 cycle; _frame_done=1 only in DONE.
//  _in_done in IDLE with no valid: go straight through DRAIN/DONE, giving an empty frame with a pulse.
//  Counters saturate at 16'hFFFF; they hold their values after a frame until the next frame starts.
//  Pointers wrap modulo DEPTH; full/empty are derived from an extra pointer MSB.
// STRUCTURE
//  Package coord_fb_pkg: state_t enum {IDLE,RUN,DRAIN,DONE}; localparams for the counter width (16)
//   and a default framebuffer geometry shared with the display reader.
//  Sub-module coord_fifo: synchronous FIFO (DEPTH x (ADDR_W+COLOR_W)), push/pop/full/empty.
//  Top-level: clip/address logic, FSM, counters, and the _overflow flag.
// TESTING
//  1 Vertical line (23,17)..(23,21), color 8'h5A, _mem_ready=1 -> addrs 1111,1175,1239,1303,1367;
//    _pix_count=5; _frame_done one cycle after the last write.
//  2 Stream (-1,0),(64,0),(0,48),(63,47) -> single write addr 3071; _clip_count=3, _pix_count=1.
//  3 _mem_ready=0 for 20 cycles with 12 valid coordinates -> _in_ready drops after 8 accepts;
//    no addr changes while stalled; all accepted pixels written in order after release.
//  4 Hold _in_valid while full, ignoring _in_ready -> _overflow=1 and stays set;
//    the next frame's first accept clears it.
//  5 _reset asserted in RUN with 4 pixels queued -> next cycle _mem_we=0, counters 0, state IDLE;
//    no stale write afterwards.
//  6 _in_done together with the final valid coordinate (0,0) -> addr 0 written, then _frame_done;
//    _in_done alone in IDLE -> _frame_done with _pix_count=0.

Source files
------------

// File: rtl/coord_fb_pkg.sv
// Shared types and constants for the coordinate framebuffer writer and display reader.
package coord_fb_pkg;

    // Frame sequencing states of the writer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of the per-frame statistics counters.
    localparam int CNT_W = 16;

    // Default framebuffer geometry, shared with the display reader.
    localparam int DEF_FB_W    = 64;
    localparam int DEF_FB_H    = 48;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_COLOR_W = 8;
    localparam int DEF_DEPTH   = 8;

endpackage

// File: rtl/coord_fifo.sv
// Synchronous FIFO holding {address, color} pixel entries between the clipper and the RAM port.
// The head entry is read straight out of the register array, so it is valid one cycle after push.
module coord_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     _clock,
    input  logic                     _reset,
    input  logic                     _push,
    input  logic                     _pop,
    input  logic [WIDTH-1:0]         _din,
    output logic [WIDTH-1:0]         _dout,
    output logic                     _full,
    output logic                     _empty,
    output logic [$clog2(DEPTH):0]   _count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra MSB so that equal low bits distinguish full from empty.
    assign _empty = (wr_ptr == rd_ptr);
    assign _full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign _count = wr_ptr - rd_ptr;
    assign _dout  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; a push while full or a pop while empty is ignored.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (_push && !_full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (_pop && !_empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage; data is not reset, the pointers alone define what is valid.
    always_ff @(posedge _clock) begin
        if (_push && !_full) begin
            mem[wr_ptr[AW-1:0]] <= _din;
        end
    end

endmodule

// File: rtl/coord_fb_writer.sv
// Clips a signed (x,y) coordinate stream to the framebuffer, queues surviving pixels and
// writes them to a single-port RAM, with per-frame statistics and an end-of-frame pulse.
module coord_fb_writer
    import coord_fb_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int FB_W    = DEF_FB_W,
    parameter int FB_H    = DEF_FB_H,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                     _clock,
    input  logic                     _reset,
    input  logic                     _in_valid,
    input  logic signed [IN_W-1:0]   _in_x,
    input  logic signed [IN_W-1:0]   _in_y,
    input  logic                     _in_done,
    output logic                     _in_ready,
    input  logic [COLOR_W-1:0]       _color,
    output logic                     _mem_we,
    output logic [ADDR_W-1:0]        _mem_addr,
    output logic [COLOR_W-1:0]       _mem_data,
    input  logic                     _mem_ready,
    output logic                     _busy,
    output logic                     _frame_done,
    output logic [CNT_W-1:0]         _pix_count,
    output logic [CNT_W-1:0]         _clip_count,
    output logic                     _overflow
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam logic signed [IN_W-1:0] ZERO_S = '0;
    localparam logic signed [IN_W-1:0] FB_W_S = IN_W'(FB_W);
    localparam logic signed [IN_W-1:0] FB_H_S = IN_W'(FB_H);

    state_t             state;
    state_t             state_nxt;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PTR_W-1:0]   fifo_count;
    logic [ADDR_W-1:0]  pix_addr;
    logic               in_bounds;
    logic               accept;
    logic               push;
    logic               pop;
    logic               clip_ev;
    logic               frame_start;
    logic               drain_done;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Bounds check uses the full signed input width so huge values never alias into range.
    assign in_bounds = (_in_x >= ZERO_S) && (_in_x < FB_W_S) &&
                       (_in_y >= ZERO_S) && (_in_y < FB_H_S);

    // Only the low ADDR_W bits of y*FB_W + x survive truncation, and those depend only on
    // the low ADDR_W bits of x and y, so the product is formed at address width.
    assign pix_addr = _in_y[ADDR_W-1:0] * ADDR_W'(FB_W) + _in_x[ADDR_W-1:0];

    assign _in_ready   = !_reset && !fifo_full && ((state == IDLE) || (state == RUN));
    assign accept      = _in_valid && _in_ready;
    assign push        = accept && in_bounds;
    assign clip_ev     = accept && !in_bounds;
    assign _mem_we     = !_reset && !fifo_empty;
    assign pop         = _mem_we && _mem_ready;
    assign frame_start = (state == IDLE) && (accept || _in_done);
    // Drain completes on the edge that retires the last queued pixel (no pushes in DRAIN).
    assign drain_done  = fifo_empty || ((fifo_count == PTR_W'(1)) && pop);
    assign _busy       = (state != IDLE);
    assign _frame_done = (state == DONE);

    coord_fifo #(
        .WIDTH (ADDR_W + COLOR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        ._clock (_clock),
        ._reset (_reset),
        ._push  (push),
        ._pop   (pop),
        ._din   ({pix_addr, _color}),
        ._dout  ({_mem_addr, _mem_data}),
        ._full  (fifo_full),
        ._empty (fifo_empty),
        ._count (fifo_count)
    );

    // Frame sequencing: a frame starts on the first accept or a bare done, ends after draining.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = _in_done ? DRAIN : RUN;
            RUN:     if (_in_done) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Statistics and overflow flag: cleared at frame start, then that cycle's event is counted.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            _pix_count  <= '0;
            _clip_count <= '0;
            _overflow   <= 1'b0;
        end else if (frame_start) begin
            _pix_count  <= CNT_W'(pop);
            _clip_count <= CNT_W'(clip_ev);
            _overflow   <= 1'b0;
        end else begin
            if (pop) begin
                _pix_count <= sat_inc(_pix_count);
            end
            if (clip_ev) begin
                _clip_count <= sat_inc(_clip_count);
            end
            if (_in_valid && fifo_full) begin
                _overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coord_fb_writer.sv
// Randomized and directed bench for coord_fb_writer with a transaction-level reference model.
module tb_coord_fb_writer;

    localparam int FB_W  = 64;
    localparam int FB_H  = 48;
    localparam int DEPTH = 8;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [31:0] in_x;
    logic signed [31:0] in_y;
    logic               in_done;
    logic               in_ready;
    logic [7:0]         color;
    logic               mem_we;
    logic [11:0]        mem_addr;
    logic [7:0]         mem_data;
    logic               mem_ready;
    logic               busy;
    logic               frame_done;
    logic [15:0]        pix_count;
    logic [15:0]        clip_count;
    logic               overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_st = S_IDLE;
    logic [19:0] mq[$];
    int          m_pix = 0;
    int          m_clip = 0;
    bit          m_ovf = 0;

    bit      chk_en = 0;
    bit      rnd_mode = 0;
    int      cyc = 0;
    int      last_wr_cyc = 0;
    int      fd_gap = 0;
    int      wlog[$];

    coord_fb_writer dut (
        ._clock      (clk),
        ._reset      (rst),
        ._in_valid   (in_valid),
        ._in_x       (in_x),
        ._in_y       (in_y),
        ._in_done    (in_done),
        ._in_ready   (in_ready),
        ._color      (color),
        ._mem_we     (mem_we),
        ._mem_addr   (mem_addr),
        ._mem_data   (mem_data),
        ._mem_ready  (mem_ready),
        ._busy       (busy),
        ._frame_done (frame_done),
        ._pix_count  (pix_count),
        ._clip_count (clip_count),
        ._overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: a queue of pending pixels plus the frame rules, advanced once per edge.
    task automatic model_step();
        bit rdy, we, acc, pop, inb, start;
        int x, y;
        if (rst) begin
            m_st = S_IDLE; mq.delete(); m_pix = 0; m_clip = 0; m_ovf = 0;
            return;
        end
        rdy   = (mq.size() < DEPTH) && (m_st == S_IDLE || m_st == S_RUN);
        we    = (mq.size() > 0);
        acc   = in_valid && rdy;
        pop   = we && mem_ready;
        x     = in_x;
        y     = in_y;
        inb   = (x >= 0) && (x < FB_W) && (y >= 0) && (y < FB_H);
        start = (m_st == S_IDLE) && (acc || in_done);
        if (start) begin
            m_pix = 0; m_clip = 0; m_ovf = 0;
        end
        if (in_valid && mq.size() == DEPTH) m_ovf = 1;
        if (acc && !inb && m_clip < 65535) m_clip++;
        if (pop && m_pix < 65535) m_pix++;
        if (pop) void'(mq.pop_front());
        if (acc && inb) mq.push_back({12'(y * FB_W + x), color});
        case (m_st)
            S_IDLE:  if (start) m_st = in_done ? S_DRAIN : S_RUN;
            S_RUN:   if (in_done) m_st = S_DRAIN;
            S_DRAIN: if (mq.size() == 0) m_st = S_DONE;
            default: m_st = S_IDLE;
        endcase
    endtask

    always @(posedge clk) model_step();

    always @(posedge clk) begin
        #1;
        if (rnd_mode) mem_ready = ($urandom_range(0, 3) != 0);
    end

    // Per-cycle comparison of every output against the model, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("in_ready", 32'(in_ready),
                  32'(!rst && mq.size() < DEPTH && (m_st == S_IDLE || m_st == S_RUN)));
            check("mem_we", 32'(mem_we), 32'(!rst && mq.size() > 0));
            if (!rst) begin
                if (mq.size() > 0) begin
                    check("mem_addr", 32'(mem_addr), 32'(mq[0][19:8]));
                    check("mem_data", 32'(mem_data), 32'(mq[0][7:0]));
                end
                check("busy", 32'(busy), 32'(m_st != S_IDLE));
                check("frame_done", 32'(frame_done), 32'(m_st == S_DONE));
                check("pix_count", 32'(pix_count), 32'(m_pix));
                check("clip_count", 32'(clip_count), 32'(m_clip));
                check("overflow", 32'(overflow), 32'(m_ovf));
                if (mem_we && mem_ready) begin
                    wlog.push_back(int'(mem_addr));
                    last_wr_cyc = cyc;
                end
                if (frame_done) fd_gap = cyc - last_wr_cyc;
            end
        end
    end

    task automatic send(input int x, input int y, input logic [7:0] c, input bit d);
        int n = 0;
        bit got;
        in_valid = 1'b1; in_x = x; in_y = y; color = c;
        while (!in_ready && n < 300) begin tick(); n++; end
        got = in_ready;
        in_done = d;
        tick();
        in_valid = 1'b0; in_done = 1'b0;
        check("send_accepted", 32'(got), 32'd1);
    endtask

    task automatic pulse_done();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
    endtask

    task automatic wait_frame(input int limit);
        int n = 0;
        while (!frame_done && n < limit) begin tick(); n++; end
        check("frame_done_seen", 32'(frame_done), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_log(input string nm, input int exp[$]);
        check({nm, "_count"}, 32'(wlog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check({nm, "_addr"}, (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_log[$];
        int k;
        rst = 1'b1; in_valid = 1'b0; in_x = 0; in_y = 0; in_done = 1'b0;
        color = 8'h00; mem_ready = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_pix", 32'(pix_count), 32'd0);
        check("rst_clip", 32'(clip_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // 1: vertical line, done with the last coordinate
        wlog.delete();
        for (int i = 0; i < 5; i++) send(23, 17 + i, 8'h5A, i == 4);
        wait_frame(100);
        exp_log = '{1111, 1175, 1239, 1303, 1367};
        check_log("t1", exp_log);
        check("t1_pix", 32'(pix_count), 32'd5);
        check("t1_done_gap", 32'(fd_gap), 32'd1);
        tick();

        // 2: clipping
        wlog.delete();
        send(-1, 0, 8'h11, 0); send(64, 0, 8'h22, 0); send(0, 48, 8'h33, 0);
        send(63, 47, 8'h44, 1);
        wait_frame(100);
        exp_log = '{3071};
        check_log("t2", exp_log);
        check("t2_clip", 32'(clip_count), 32'd3);
        check("t2_pix", 32'(pix_count), 32'd1);
        tick();

        // 3: stalled RAM, sender honours ready
        wlog.delete();
        mem_ready = 1'b0; k = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = in_ready && (k < 12);
            in_x = k; in_y = 5; color = 8'(k);
            if (k > 0) check("t3_stall_addr", 32'(mem_addr), 32'd320);
            tick();
            if (in_valid) k++;
        end
        in_valid = 1'b0;
        check("t3_accepts", 32'(k), 32'd8);
        check("t3_ready_low", 32'(in_ready), 32'd0);
        mem_ready = 1'b1;
        for (int i = 8; i < 12; i++) send(i, 5, 8'(i), i == 11);
        wait_frame(100);
        exp_log.delete();
        for (int i = 0; i < 12; i++) exp_log.push_back(320 + i);
        check_log("t3", exp_log);
        tick();

        // 4: overflow by ignoring ready
        mem_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1; in_x = c; in_y = 2; color = 8'(c);
            tick();
        end
        in_valid = 1'b0;
        check("t4_ovf_set", 32'(overflow), 32'd1);
        tick(); tick(); tick();
        check("t4_ovf_held", 32'(overflow), 32'd1);
        mem_ready = 1'b1;
        pulse_done();
        wait_frame(100);
        check("t4_ovf_after_frame", 32'(overflow), 32'd1);
        check("t4_pix", 32'(pix_count), 32'd8);
        tick();
        send(1, 1, 8'h01, 0);
        check("t4_ovf_cleared", 32'(overflow), 32'd0);
        send(2, 1, 8'h02, 1);
        wait_frame(100);
        tick();

        // 5: reset mid-frame with pixels queued
        wlog.delete();
        mem_ready = 1'b0;
        send(-5, 3, 8'h00, 0);
        for (int i = 0; i < 4; i++) send(i, 9, 8'h77, 0);
        check("t5_clip_before", 32'(clip_count), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_ready_in_reset", 32'(in_ready), 32'd0);
        check("t5_we_in_reset", 32'(mem_we), 32'd0);
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("t5_we_after", 32'(mem_we), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);
        check("t5_clip_after", 32'(clip_count), 32'd0);
        check("t5_pix_after", 32'(pix_count), 32'd0);
        repeat (10) tick();
        check("t5_no_stale_write", 32'(wlog.size()), 32'd0);

        // 6: done with final coordinate, then bare done
        wlog.delete();
        send(0, 0, 8'hC3, 1);
        wait_frame(100);
        exp_log = '{0};
        check_log("t6", exp_log);
        check("t6_done_gap", 32'(fd_gap), 32'd1);
        tick();
        pulse_done();
        wait_frame(100);
        check("t6_empty_pix", 32'(pix_count), 32'd0);
        check("t6_empty_clip", 32'(clip_count), 32'd0);
        tick();

        // Randomized frames with random RAM back-pressure
        rnd_mode = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int n;
            bit fold;
            n = $urandom_range(1, 24);
            fold = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++) begin
                int x, y;
                repeat ($urandom_range(0, 2)) tick();
                x = int'($urandom_range(0, 80)) - 8;
                y = int'($urandom_range(0, 64)) - 8;
                if ($urandom_range(0, 15) == 0) x = 32'h8000_0010;
                if ($urandom_range(0, 15) == 0) y = 32'h7FFF_FFF0;
                send(x, y, 8'($urandom), fold && (i == n - 1));
            end
            if (!fold) begin
                repeat ($urandom_range(0, 3)) tick();
                pulse_done();
            end
            wait_frame(1000);
            tick();
        end
        rnd_mode = 1'b0;
        tick();
        mem_ready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
